plane_fetch: RTL

Per-plane video line fetcher for the MCD212 display path. At each line start it reads a run of 16-bit pixel words from video RAM through the same address/as/bus_ack handshake the ICA/DCA controller uses. It buffers the words in a small FIFO and hands out one 8-bit CLUT index per pixel strobe to the CLUT lookup stage downstream.

---
 rtl/plane_fetch_pkg.sv | 24 ++
 rtl/plane_fetch_word_fifo.sv | 71 +++++++
 rtl/plane_fetch.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/plane_fetch_pkg.sv
// Shared types and constants for the per-plane video line fetcher.
package plane_fetch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        GAP   = 2'd2,
        ABORT = 2'd3
    } fetch_state_t;

    localparam logic [3:0] CODING_CLUT8 = 4'b0001;
    localparam logic [3:0] CODING_CLUT7 = 4'b0011;

    function automatic logic [7:0] clut_index(input logic [7:0] pix_byte, input logic clut7);
        logic [7:0] idx;
        if (clut7) begin
            idx = {1'b0, pix_byte[6:0]};
        end else begin
            idx = pix_byte;
        end
        return idx;
    endfunction

endpackage

// File: rtl/plane_fetch_word_fifo.sv
// Synchronous word FIFO with flush; the read word is visible on dout_o as soon
// as it is counted, i.e. the cycle after the push edge.
module word_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 16
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           din_i,
    input  logic                       pop_i,
    input  logic                       flush_i,
    output logic [WIDTH-1:0]           dout_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       empty_o,
    output logic                       full_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q, wr_d;
    logic [AW-1:0]    rd_q, rd_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push_s;
    logic             do_pop_s;

    assign empty_o   = (count_q == {CW{1'b0}});
    assign full_o    = (count_q == CW'(DEPTH));
    assign count_o   = count_q;
    assign dout_o    = mem_q[rd_q];
    assign do_push_s = push_i && !full_o;
    assign do_pop_s  = pop_i && !empty_o;

    // Pointer and occupancy next-state; flush discards any same-cycle push/pop.
    always_comb begin
        wr_d    = wr_q;
        rd_d    = rd_q;
        count_d = count_q;
        if (flush_i) begin
            wr_d    = {AW{1'b0}};
            rd_d    = {AW{1'b0}};
            count_d = {CW{1'b0}};
        end else begin
            wr_d    = do_push_s ? wr_q + {{(AW-1){1'b0}}, 1'b1} : wr_q;
            rd_d    = do_pop_s  ? rd_q + {{(AW-1){1'b0}}, 1'b1} : rd_q;
            count_d = count_q + {{(CW-1){1'b0}}, do_push_s} - {{(CW-1){1'b0}}, do_pop_s};
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_q    <= {AW{1'b0}};
            rd_q    <= {AW{1'b0}};
            count_q <= {CW{1'b0}};
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
        end
    end

    // Storage array; contents are don't-care while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (do_push_s && !flush_i) begin
            mem_q[wr_q] <= din_i;
        end
    end

endmodule

// File: rtl/plane_fetch.sv
// Per-plane line fetcher: reads 16-bit words over the as/bus_ack handshake and
// hands out one CLUT index per pixel strobe. Optional: PLANE_FETCH_UNDERFLOW_COUNT_EN.
module plane_fetch
    import plane_fetch_pkg::*;
#(
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        line_start,
    input  logic [21:0] line_address,
    input  logic [8:0]  line_words,
    input  logic [3:0]  coding_method,
    output logic [21:0] address,
    output logic        as,
    input  logic [15:0] din,
    input  logic        bus_ack,
    input  logic        pixel_strobe,
    output logic [7:0]  pixel_index,
    output logic        pixel_valid,
    output logic        underflow
`ifdef PLANE_FETCH_UNDERFLOW_COUNT_EN
    ,
    output logic [15:0] underflow_count
`endif
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    fetch_state_t    state_q, state_d;
    logic [20:0]     waddr_q, waddr_d;
    logic [8:0]      rem_q, rem_d;
    logic [20:0]     pend_waddr_q, pend_waddr_d;
    logic [8:0]      pend_words_q, pend_words_d;
    logic            pend_on_q, pend_on_d;
    logic            phase_q, phase_d;
    logic [7:0]      index_q, index_d;
    logic            valid_q, valid_d;
    logic            unf_q, unf_d;

    logic            fifo_push_s, fifo_pop_s, fifo_flush_s;
    logic            fifo_empty_s, fifo_full_s;
    logic [15:0]     fifo_dout_s;
    logic [CW-1:0]   fifo_count_s;

    logic            plane_on_s, clut7_s, line_pending_s;
    logic            apply_s, apply_to_gap_s, apply_on_s;
    logic [20:0]     apply_waddr_s;
    logic [8:0]      apply_words_s;
    logic [7:0]      pix_byte_s;

    assign plane_on_s     = (coding_method == CODING_CLUT8) || (coding_method == CODING_CLUT7);
    assign clut7_s        = (coding_method == CODING_CLUT7);
    assign line_pending_s = (rem_q != 9'd0) || (state_q == REQ) || (state_q == ABORT);
    assign pix_byte_s     = phase_q ? fifo_dout_s[7:0] : fifo_dout_s[15:8];

    assign address     = {waddr_q, 1'b0};
    assign as          = (state_q == REQ) || (state_q == ABORT);
    assign pixel_index = index_q;
    assign pixel_valid = valid_q;
    assign underflow   = unf_q;

    word_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (16)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push_i  (fifo_push_s),
        .din_i   (din),
        .pop_i   (fifo_pop_s),
        .flush_i (fifo_flush_s),
        .dout_o  (fifo_dout_s),
        .count_o (fifo_count_s),
        .empty_o (fifo_empty_s),
        .full_o  (fifo_full_s)
    );

    // Fetch FSM, pixel unpacking and line (re)start handling.
    always_comb begin
        state_d        = state_q;
        waddr_d        = waddr_q;
        rem_d          = rem_q;
        pend_waddr_d   = pend_waddr_q;
        pend_words_d   = pend_words_q;
        pend_on_d      = pend_on_q;
        phase_d        = phase_q;
        index_d        = index_q;
        valid_d        = valid_q;
        unf_d          = unf_q;
        fifo_push_s    = 1'b0;
        fifo_pop_s     = 1'b0;
        fifo_flush_s   = 1'b0;
        apply_s        = 1'b0;
        apply_to_gap_s = 1'b0;
        apply_waddr_s  = line_address[21:1];
        apply_words_s  = line_words;
        apply_on_s     = plane_on_s;

        case (state_q)
            IDLE: begin
                apply_s = line_start;
            end
            GAP: begin
                if (line_start) begin
                    apply_s = 1'b1;
                end else if (rem_q == 9'd0) begin
                    state_d = IDLE;
                end else if (fifo_count_s < CW'(FIFO_DEPTH)) begin
                    state_d = REQ;
                end else begin
                    state_d = GAP;
                end
            end
            REQ: begin
                if (line_start) begin
                    pend_waddr_d = line_address[21:1];
                    pend_words_d = line_words;
                    pend_on_d    = plane_on_s;
                    if (bus_ack) begin
                        apply_s        = 1'b1;
                        apply_to_gap_s = 1'b1;
                    end else begin
                        state_d = ABORT;
                    end
                end else if (bus_ack) begin
                    fifo_push_s = 1'b1;
                    waddr_d     = waddr_q + 21'd1;
                    rem_d       = rem_q - 9'd1;
                    state_d     = GAP;
                end else begin
                    state_d = REQ;
                end
            end
            ABORT: begin
                // A newer line_start overrides the pending one; the acked word is dropped.
                if (line_start) begin
                    pend_waddr_d = line_address[21:1];
                    pend_words_d = line_words;
                    pend_on_d    = plane_on_s;
                end else begin
                    apply_waddr_s = pend_waddr_q;
                    apply_words_s = pend_words_q;
                    apply_on_s    = pend_on_q;
                end
                if (bus_ack) begin
                    apply_s        = 1'b1;
                    apply_to_gap_s = 1'b1;
                end else begin
                    state_d = ABORT;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (pixel_strobe) begin
            if (plane_on_s && !fifo_empty_s) begin
                index_d    = clut_index(pix_byte_s, clut7_s);
                valid_d    = 1'b1;
                phase_d    = !phase_q;
                fifo_pop_s = phase_q;
            end else begin
                index_d = 8'h00;
                valid_d = 1'b0;
                unf_d   = unf_q | (plane_on_s && line_pending_s);
            end
        end else begin
            index_d = index_q;
        end

        if (line_start) begin
            unf_d = 1'b0;
        end else begin
            unf_d = unf_d;
        end

        // Coming out of ABORT as is still high, so it must pass through GAP first.
        if (apply_s) begin
            fifo_flush_s = 1'b1;
            phase_d      = 1'b0;
            if (apply_on_s && (apply_words_s != 9'd0)) begin
                waddr_d = apply_waddr_s;
                rem_d   = apply_words_s;
                state_d = apply_to_gap_s ? GAP : REQ;
            end else begin
                rem_d   = 9'd0;
                state_d = IDLE;
            end
        end else begin
            fifo_flush_s = 1'b0;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            waddr_q      <= 21'd0;
            rem_q        <= 9'd0;
            pend_waddr_q <= 21'd0;
            pend_words_q <= 9'd0;
            pend_on_q    <= 1'b0;
            phase_q      <= 1'b0;
            index_q      <= 8'h00;
            valid_q      <= 1'b0;
            unf_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            waddr_q      <= waddr_d;
            rem_q        <= rem_d;
            pend_waddr_q <= pend_waddr_d;
            pend_words_q <= pend_words_d;
            pend_on_q    <= pend_on_d;
            phase_q      <= phase_d;
            index_q      <= index_d;
            valid_q      <= valid_d;
            unf_q        <= unf_d;
        end
    end

`ifdef PLANE_FETCH_UNDERFLOW_COUNT_EN
    logic [15:0] ucount_q;
    logic        unf_hit_s;

    assign unf_hit_s       = pixel_strobe && plane_on_s && fifo_empty_s && line_pending_s;
    assign underflow_count = ucount_q;

    // Saturating count of underflowing strobes; only reset clears it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ucount_q <= 16'd0;
        end else if (unf_hit_s && (ucount_q != 16'hFFFF)) begin
            ucount_q <= ucount_q + 16'd1;
        end else begin
            ucount_q <= ucount_q;
        end
    end
`endif

endmodule
